// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_ROR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiplier and 1-bit-per-cycle shifter/rotator.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SHW-1:0]   amount,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHW-1:0]   count_q;
  logic [WIDTH-1:0] step;

  // Effective step count for the op presented at the inputs; MUL always takes WIDTH steps.
  always_comb begin
    amount = SHW'(WIDTH);
    if (op == ALU_ROR) begin
      amount = b[SHW-1:0] % SHW'(WIDTH);
    end else if (op != ALU_MUL) begin
      amount = (b >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : b[SHW-1:0];
    end
  end

  always_comb begin
    step = acc_q;
    case (op_q)
      ALU_MUL: step = mplier_q[0] ? acc_q + mcand_q : acc_q;
      ALU_SLL: step = {acc_q[WIDTH-2:0], 1'b0};
      ALU_SRA: step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      ALU_ROR: step = {acc_q[0], acc_q[WIDTH-1:1]};
      default: step = acc_q;
    endcase
  end

  // The final step's value is offered combinationally so the top can register it on the same edge.
  assign done   = (count_q == SHW'(1));
  assign result = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= ALU_FWD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start) begin
      op_q     <= op;
      count_q  <= amount;
      acc_q    <= (op == ALU_MUL) ? '0 : a;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (count_q != '0) begin
      acc_q    <= step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: handshake FSM, single-cycle logic ops inline, iterative ops in alu_iter_unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  input  logic [2:0]       ALUOP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic [1:0]       dbg_state
);

  // Handshake: an operand set is accepted on a rising edge where IN_VALID && IN_READY;
  // a result is consumed on a rising edge where OUT_VALID && OUT_READY. The two never
  // overlap: IN_READY is high only in IDLE and OUT_VALID only in HOLD.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             carry_new;
  logic             load;
  logic             iter_start;
  logic             iter_done;
  logic [SHW-1:0]   iter_amount;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, OPERAND1} + {1'b0, OPERAND2};

  alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .start  (iter_start),
    .op     (ALUOP),
    .a      (OPERAND1),
    .b      (OPERAND2),
    .amount (iter_amount),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    carry_new  = 1'b0;
    load       = 1'b0;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          case (ALUOP)
            ALU_FWD: begin result_d = OPERAND2; load = 1'b1; end
            ALU_ADD: begin result_d = sum[WIDTH-1:0]; carry_new = sum[WIDTH]; load = 1'b1; end
            ALU_AND: begin result_d = OPERAND1 & OPERAND2; load = 1'b1; end
            ALU_OR:  begin result_d = OPERAND1 | OPERAND2; load = 1'b1; end
            ALU_MUL: iter_start = 1'b1;
            default: begin
              // A zero shift/rotate amount skips EXEC and returns the value untouched.
              if (iter_amount == '0) begin
                result_d = OPERAND1;
                load     = 1'b1;
              end else begin
                iter_start = 1'b1;
              end
            end
          endcase
          state_d = load ? ST_HOLD : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (iter_done) begin
          result_d = iter_result;
          load     = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      zero_d  = (result_d == '0);
      carry_d = carry_new;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_HOLD);
  assign RESULT    = result_q;
  assign ZERO      = zero_q;
  assign CARRY     = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: 8-bit directed vectors plus a 16-bit instance with a model sweep.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero, carry;
  logic [7:0]  op1 = '0, op2 = '0, result;
  logic [2:0]  aluop = '0;
  logic [1:0]  dbg;
  logic        in_valid_w = 1'b0, out_ready_w = 1'b1;
  logic        in_ready_w, out_valid_w, zero_w, carry_w;
  logic [15:0] op1_w = '0, op2_w = '0, result_w;
  logic [2:0]  aluop_w = '0;
  logic [1:0]  dbg_w;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  alu_multicycle #(.WIDTH(8)) dut (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OPERAND1(op1), .OPERAND2(op2), .ALUOP(aluop), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .RESULT(result), .ZERO(zero), .CARRY(carry), .dbg_state(dbg)
  );

  alu_multicycle #(.WIDTH(16)) dut_w (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid_w), .IN_READY(in_ready_w),
    .OPERAND1(op1_w), .OPERAND2(op2_w), .ALUOP(aluop_w), .OUT_VALID(out_valid_w),
    .OUT_READY(out_ready_w), .RESULT(result_w), .ZERO(zero_w), .CARRY(carry_w), .dbg_state(dbg_w)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver for the 8-bit instance: present one op, wait for its result, score it.
  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_res, input logic exp_zero, input logic exp_carry,
                      input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; aluop = op; op1 = a; op2 = b;
    exp_q.push_back(exp_res);
    tick();
    in_valid = 1'b0; op1 = ~a; op2 = ~b; aluop = ~op;
    lat = 1;
    while (!out_valid && lat < 64) begin
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp_q.pop_front()));
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check({tag, "_carry"}, 32'(carry), 32'(exp_carry));
    check({tag, "_state"}, 32'(dbg), 32'd2);
    if (out_ready) begin
      tick();
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  function automatic logic [15:0] model16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] t;
    logic [15:0] r;
    int amt;
    case (op)
      3'd0: r = b;
      3'd1: r = a + b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a * b;
      3'd5: r = (b >= 16'd16) ? 16'h0 : (a << b);
      3'd6: r = (b >= 16'd16) ? {16{a[15]}} : 16'($signed(a) >>> b);
      default: begin
        amt = int'(b[4:0]) % 16;
        t = {a, a} >> amt;
        r = t[15:0];
      end
    endcase
    return r;
  endfunction

  function automatic int lat16(input logic [2:0] op, input logic [15:0] b);
    int amt;
    if (op < 3'd4) return 1;
    if (op == 3'd4) return 17;
    amt = (op == 3'd7) ? int'(b[4:0]) % 16 : ((b >= 16'd16) ? 16 : int'(b));
    return (amt == 0) ? 1 : amt + 1;
  endfunction

  // Driver for the 16-bit instance, scored against model16.
  task automatic run16(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int lat;
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    check({tag, "_ready"}, 32'(in_ready_w), 32'd1);
    in_valid_w = 1'b1; aluop_w = op; op1_w = a; op2_w = b;
    tick();
    in_valid_w = 1'b0; op1_w = ~a; op2_w = ~b;
    lat = 1;
    while (!out_valid_w && lat < 64) begin tick(); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(lat16(op, b)));
    check({tag, "_res"}, 32'(result_w), 32'(model16(op, a, b)));
    check({tag, "_zero"}, 32'(zero_w), 32'(model16(op, a, b) == 16'h0));
    check({tag, "_carry"}, 32'(carry_w), 32'((op == 3'd1) ? s[16] : 1'b0));
    tick();
  endtask

  initial begin
    logic seen;
    logic [2:0] rop;
    logic [15:0] ra, rb;

    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_state", 32'(dbg), 32'd0);

    run8("add_5_4",    3'd1, 8'h05, 8'h04, 8'h09, 1'b0, 1'b0, 1);
    run8("add_ff_1",   3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);
    run8("mul_d_b",    3'd4, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 9);
    run8("mul_10_10",  3'd4, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9);
    run8("sra_a0_3",   3'd6, 8'hA0, 8'h03, 8'hF4, 1'b0, 1'b0, 4);
    run8("sll_a0_9",   3'd5, 8'hA0, 8'h09, 8'h00, 1'b1, 1'b0, 9);
    run8("ror_81_9",   3'd7, 8'h81, 8'h09, 8'hC0, 1'b0, 1'b0, 2);
    run8("sll_a0_0",   3'd5, 8'hA0, 8'h00, 8'hA0, 1'b0, 1'b0, 1);
    run8("sra_80_ff",  3'd6, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0, 9);
    run8("fwd_3c",     3'd0, 8'h11, 8'h3C, 8'h3C, 1'b0, 1'b0, 1);

    // Back-pressure: result must hold while a second request is ignored.
    out_ready = 1'b0;
    run8("and_f0_0a",  3'd2, 8'hF0, 8'h0A, 8'h00, 1'b1, 1'b0, 1);
    in_valid = 1'b1; aluop = 3'd3; op1 = 8'hFF; op2 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'h00);
      check("hold_zero", 32'(zero), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("release_idle", 32'(in_ready), 32'd1);
    check("release_drop", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("or_valid", 32'(out_valid), 32'd1);
    check("or_result", 32'(result), 32'hFF);
    check("or_zero", 32'(zero), 32'd0);
    tick();

    // Reset during the fourth MUL cycle discards the operation.
    run8("add_ff_2",   3'd1, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b1, 1);
    in_valid = 1'b1; aluop = 3'd4; op1 = 8'h0D; op2 = 8'h0B;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_exec_state", 32'(dbg), 32'd1);
    check("mid_exec_result", 32'(result), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dbg), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    run8("fwd_0a",     3'd0, 8'h77, 8'h0A, 8'h0A, 1'b0, 1'b0, 1);

    // 16-bit instance: directed cases then a model-checked sweep.
    run16("w_mul", 3'd4, 16'h0101, 16'h00FF);
    check("w_mul_value", 32'(model16(3'd4, 16'h0101, 16'h00FF)), 32'hFFFF);
    run16("w_ror", 3'd7, 16'h0001, 16'h0001);
    check("w_ror_value", 32'(model16(3'd7, 16'h0001, 16'h0001)), 32'h8000);
    run16("w_add_carry", 3'd1, 16'hFFFF, 16'h0001);
    run16("w_sra_sat", 3'd6, 16'h8001, 16'h0020);
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = (rop >= 3'd5) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      run16("w_rand", rop, ra, rb);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
